gf251_vec_add_ctrl: RTL and testbench

Sequencer that streams two operand vectors of packed GF(251) words (4 × 8-bit lanes per 32-bit word) from dual read memories through one gf251_add_32 instance, and writes the sums to a result memory. It issues one read per cycle, feeds the adder back-to-back, and counts the adder's done pulses to address the write-back. It sits between the vector BRAMs and the shared adder in the SDitH arithmetic datapath.

---
 rtl/gf251_vec_add_ctrl.sv | 80 ++++++++
 tb/tb_gf251_vec_add_ctrl.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/gf251_vec_add_ctrl.sv
// gf251_vec_add_ctrl: streams X/Y word vectors through one gf251_add_32 and writes sums to a result memory.
// Define GF251_CTRL_RANGE_CHECK_EN to add the sticky o_range_err non-canonical operand flag.
module gf251_vec_add_ctrl #(
  parameter int N_WORDS = 16,
  parameter int AW = 4
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_start,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_rd_en,
  output logic [AW-1:0] o_rd_addr,
  input  logic [31:0]   i_x_data,
  input  logic [31:0]   i_y_data,
  output logic          o_add_start,
  output logic [31:0]   o_add_x,
  output logic [31:0]   o_add_y,
  input  logic [31:0]   i_add_o,
  input  logic          i_add_done,
  output logic          o_wr_en,
  output logic [AW-1:0] o_wr_addr,
  output logic [31:0]   o_wr_data
`ifdef GF251_CTRL_RANGE_CHECK_EN
  ,
  output logic          o_range_err
`endif
);
  localparam logic [1:0] IDLE = 2'd0, ISSUE = 2'd1, DRAIN = 2'd2, DONE = 2'd3;
  logic [1:0] state, state_nxt;
  logic [AW-1:0] rd_cnt;
  logic [AW:0] wr_cnt;
  logic rd_last, wr_full, wr_take;
  assign rd_last = rd_cnt == AW'(N_WORDS - 1);
  assign wr_full = wr_cnt == (AW+1)'(N_WORDS);
  // late dones after reset or beyond the vector length are dropped here
  assign wr_take = i_add_done && state != IDLE && !wr_full;
  assign o_rd_en = state == ISSUE;
  assign o_rd_addr = rd_cnt;
  assign o_busy = state == ISSUE || state == DRAIN;
  assign o_done = state == DONE;
  assign o_add_x = i_x_data;
  assign o_add_y = i_y_data;
  always_comb begin
    state_nxt = state == IDLE  ? (i_start ? ISSUE : IDLE) :
                state == ISSUE ? (rd_last ? DRAIN : ISSUE) :
                state == DRAIN ? (wr_full ? DONE : DRAIN) : IDLE;
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
      rd_cnt <= '0;
      wr_cnt <= '0;
      o_add_start <= 1'b0;
      o_wr_en <= 1'b0;
      o_wr_addr <= '0;
      o_wr_data <= '0;
    end else begin
      state <= state_nxt;
      rd_cnt <= state == IDLE ? '0 : (state == ISSUE && !rd_last) ? rd_cnt + 1'b1 : rd_cnt;
      wr_cnt <= state == IDLE ? '0 : wr_take ? wr_cnt + 1'b1 : wr_cnt;
      o_add_start <= o_rd_en;
      o_wr_en <= wr_take;
      if (wr_take) begin
        o_wr_addr <= wr_cnt[AW-1:0];
        o_wr_data <= i_add_o;
      end
    end
  end
`ifdef GF251_CTRL_RANGE_CHECK_EN
  function automatic logic non_canon(input logic [31:0] w);
    non_canon = 1'b0;
    for (int i = 0; i < 4; i++) non_canon = non_canon | (w[8*i +: 8] >= 8'hFB);
  endfunction
  always_ff @(posedge i_clk) begin
    if (i_rst || (state == IDLE && i_start)) o_range_err <= 1'b0;
    else if (o_add_start && (non_canon(o_add_x) || non_canon(o_add_y))) o_range_err <= 1'b1;
  end
`endif
endmodule

// File: tb/tb_gf251_vec_add_ctrl.sv
// tb_gf251_vec_add_ctrl: directed vector runs against X/Y memory and variable-latency adder models.
module tb_gf251_vec_add_ctrl;
  logic i_clk = 1'b0, i_rst = 1'b1, i_start = 1'b0;
  logic o_busy, o_done, o_rd_en, o_add_start, o_wr_en, i_add_done;
  logic [3:0] o_rd_addr, o_wr_addr;
  logic [31:0] i_x_data = '0, i_y_data = '0, o_add_x, o_add_y, i_add_o, o_wr_data;
`ifdef GF251_CTRL_RANGE_CHECK_EN
  logic o_range_err;
  logic re_log [0:31];
`endif
  int n_cmp = 0, n_bad = 0, lat = 1;
  logic [31:0] xm [0:15], ym [0:15];
  logic [7:0] pv = '0;
  logic [31:0] pd [0:7];

  gf251_vec_add_ctrl #(.N_WORDS(3), .AW(4)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .o_busy(o_busy), .o_done(o_done),
    .o_rd_en(o_rd_en), .o_rd_addr(o_rd_addr), .i_x_data(i_x_data), .i_y_data(i_y_data),
    .o_add_start(o_add_start), .o_add_x(o_add_x), .o_add_y(o_add_y), .i_add_o(i_add_o),
    .i_add_done(i_add_done), .o_wr_en(o_wr_en), .o_wr_addr(o_wr_addr), .o_wr_data(o_wr_data)
`ifdef GF251_CTRL_RANGE_CHECK_EN
    , .o_range_err(o_range_err)
`endif
  );

  always #5 i_clk = ~i_clk;

  function automatic logic [31:0] gfadd(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = 8'((int'(a[8*i +: 8]) + int'(b[8*i +: 8])) % 251);
    return r;
  endfunction

  always @(posedge i_clk) begin
    if (o_rd_en) begin
      i_x_data <= xm[o_rd_addr];
      i_y_data <= ym[o_rd_addr];
    end
    pv <= {pv[6:0], o_add_start};
    pd[0] <= gfadd(o_add_x, o_add_y);
    for (int i = 1; i < 8; i++) pd[i] <= pd[i-1];
  end
  assign i_add_done = pv[lat-1];
  assign i_add_o = pd[lat-1];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run(input int l, input int g1, input int g2, input logic [0:2][31:0] e, input string tag);
    int rd_n = 0, rd_bad = 0, as_n = 0, as_bad = 0, wr_n = 0, done_n = 0, done_c = 0, busy_bad = 0;
    logic [31:0] wa [0:7];
    logic [31:0] wd [0:7];
    lat = l;
    @(negedge i_clk) i_start = 1'b1;
    @(negedge i_clk) i_start = 1'b0;
    for (int c = 1; c <= 30; c++) begin
      if (o_rd_en) begin
        rd_n++;
        if (c != rd_n || o_rd_addr != 4'(rd_n - 1)) rd_bad++;
      end
      if (o_add_start) begin
        as_n++;
        if (c != as_n + 1) as_bad++;
      end
      if (o_wr_en) begin
        if (wr_n < 8) begin
          wa[wr_n] = {28'd0, o_wr_addr};
          wd[wr_n] = o_wr_data;
        end
        wr_n++;
      end
      if (o_busy != (done_n == 0 && !o_done)) busy_bad++;
      if (o_done) begin
        done_n++;
        done_c = c;
      end
`ifdef GF251_CTRL_RANGE_CHECK_EN
      re_log[c] = o_range_err;
`endif
      i_start = (c == g1 || c == g2);
      @(negedge i_clk);
    end
    i_start = 1'b0;
    chk({tag, " rd count"}, rd_n, 3);
    chk({tag, " rd order"}, rd_bad, 0);
    chk({tag, " add_start count"}, as_n, 3);
    chk({tag, " add_start timing"}, as_bad, 0);
    chk({tag, " wr count"}, wr_n, 3);
    for (int i = 0; i < 3 && i < wr_n; i++) begin
      chk($sformatf("%s wr%0d addr", tag, i), wa[i], i);
      chk($sformatf("%s wr%0d data", tag, i), wd[i], e[i]);
    end
    chk({tag, " done count"}, done_n, 1);
    chk({tag, " done cycle"}, done_c, 6 + l);
    chk({tag, " busy shape"}, busy_bad, 0);
  endtask

  typedef struct {
    int lat;
    int g1;
    int g2;
    logic [0:2][31:0] x;
    logic [0:2][31:0] y;
    logic [0:2][31:0] e;
  } vec_t;
  vec_t tv [0:3];

  task automatic load(input logic [0:2][31:0] x, input logic [0:2][31:0] y);
    for (int i = 0; i < 3; i++) begin
      xm[i] = x[i];
      ym[i] = y[i];
    end
  endtask

  initial begin
    int wr_seen;
    tv[0] = '{1, 0, 0, {32'h22222222, 32'hFAFAFAFA, 32'h12345678},
              {32'h44444444, 32'hFAFAFAFA, 32'h87654321}, {32'h66666666, 32'hF9F9F9F9, 32'h99999999}};
    tv[1] = '{4, 0, 0, tv[0].x, tv[0].y, tv[0].e};
    tv[2] = '{2, 2, 5, tv[0].x, tv[0].y, tv[0].e};
    tv[3] = '{3, 9, 0, {32'h00FA0102, 32'h7D7D7D7D, 32'h00000000},
              {32'h00010203, 32'h7E7E7E7E, 32'hFAFAFAFA}, {32'h00000305, 32'h00000000, 32'hFAFAFAFA}};
    for (int i = 0; i < 16; i++) begin
      xm[i] = '0;
      ym[i] = '0;
    end
    for (int i = 0; i < 8; i++) pd[i] = '0;
    repeat (3) @(negedge i_clk);
    chk("reset ctrl outs", {27'd0, o_busy, o_done, o_rd_en, o_add_start, o_wr_en}, 0);
    chk("reset addrs", {24'd0, o_rd_addr, o_wr_addr}, 0);
    chk("reset wr_data", o_wr_data, 0);
`ifdef GF251_CTRL_RANGE_CHECK_EN
    chk("reset range_err", {31'd0, o_range_err}, 0);
`endif
    i_rst = 1'b0;
    for (int r = 0; r < 4; r++) begin
      load(tv[r].x, tv[r].y);
      run(tv[r].lat, tv[r].g1, tv[r].g2, tv[r].e, $sformatf("row%0d", r));
    end
    // reset in DRAIN with dones still in the adder pipeline
    load(tv[0].x, tv[0].y);
    lat = 4;
    @(negedge i_clk) i_start = 1'b1;
    @(negedge i_clk) i_start = 1'b0;
    repeat (4) @(negedge i_clk);
    chk("pre-reset busy", {31'd0, o_busy}, 1);
    i_rst = 1'b1;
    @(negedge i_clk) i_rst = 1'b0;
    chk("mid reset ctrl outs", {27'd0, o_busy, o_done, o_rd_en, o_add_start, o_wr_en}, 0);
    chk("mid reset addrs", {24'd0, o_rd_addr, o_wr_addr}, 0);
    chk("mid reset wr_data", o_wr_data, 0);
    wr_seen = 0;
    for (int c = 0; c < 8; c++) begin
      if (o_wr_en) wr_seen++;
      @(negedge i_clk);
    end
    chk("stale done writes", wr_seen, 0);
    run(4, 0, 0, tv[0].e, "post_rst");
`ifdef GF251_CTRL_RANGE_CHECK_EN
    xm[1] = 32'hFFFFFFFF;
    run(1, 0, 0, {32'h66666666, 32'h03030303, 32'h99999999}, "range");
    chk("range_err before 2nd start", {31'd0, re_log[3]}, 0);
    chk("range_err after 2nd start", {31'd0, re_log[4]}, 1);
    chk("range_err sticky", {31'd0, re_log[20]}, 1);
    run(1, 0, 0, {32'h66666666, 32'h03030303, 32'h99999999}, "range2");
    chk("range_err cleared by start", {31'd0, re_log[1]}, 0);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
